// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter that shares one output port between N_IN 4-phase req/ack channels.
// Grants one channel, forwards its word through a registered stage, then rotates priority.
module rr_port_arbiter #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_req,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    output logic [N_IN-1:0]         in_ack,
    output logic                    out_req,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ack,
    output logic [$clog2(N_IN)-1:0] grant_idx,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int unsigned IdxW = $clog2(N_IN);
    localparam int unsigned WdW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_IN - 1);
    localparam logic [N_IN-1:0] AckOne  = N_IN'(1);

    typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              err_q, err_d;

    logic              req_found;
    logic [IdxW-1:0]   sel_idx;
    logic [IdxW-1:0]   cand;
    logic [DATA_W-1:0] sel_data;

    // Search ptr, ptr+1, ... (mod N_IN); the first requester found wins.
    always_comb begin
        req_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            cand = IdxW'((int'(ptr_q) + i) % int'(N_IN));
            if (!req_found && in_req[cand]) begin
                req_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < int'(N_IN); j++) begin
            if (sel_idx == IdxW'(j)) begin
                sel_data = in_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        wd_d    = wd_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    grant_d = sel_idx;
                    data_d  = sel_data;
                    wd_d    = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (out_ack) begin
                    state_d = StAck;
                end else if (TIMEOUT != 0 && wd_q != WdMax) begin
                    // Saturating watchdog; the transfer keeps waiting after the flag is raised.
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WdMax) begin
                        err_d = 1'b1;
                    end
                end
            end
            StAck: begin
                if (!in_req[grant_q] && !out_ack) begin
                    ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from state, so in_ack and out_req can never overlap.
    always_comb begin
        out_req     = (state_q == StReq);
        in_ack      = (state_q == StAck) ? (AckOne << grant_q) : '0;
        busy        = (state_q != StIdle);
        out_data    = data_q;
        grant_idx   = grant_q;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter: directed scenarios plus random traffic
// compared against a transaction-level round-robin model.
module tb_rr_port_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   in_req = '0;
    logic [W-1:0]   word [N];
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ack;
    logic           out_req;
    logic [W-1:0]   out_data;
    logic           out_ack = 1'b0;
    logic [1:0]     grant_idx;
    logic           busy;
    logic           timeout_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    logic m_err = 1'b0;

    rr_port_arbiter #(
        .N_IN   (N),
        .DATA_W (W),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = word[i];
    end

    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (!$onehot0(in_ack) || (out_req && (in_ack != '0))) begin
                n_err++;
                $display("FAIL invariant: in_ack=%b out_req=%b", in_ack, out_req);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Round-robin rule: first requester at or after the pointer, wrapping around.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer with in_req held at req; returns the observed grant.
    task automatic run_word(input logic [N-1:0] req, input int ack_delay, output int got_g);
        int g;
        bit seen;
        in_req = req;
        g = model_pick(req, m_ptr);
        step();
        got_g = int'(grant_idx);
        n_cmp++;
        if (grant_idx !== 2'(g) || out_req !== 1'b1) begin
            n_err++;
            $display("FAIL grant: got idx=%0d out_req=%b, want idx=%0d out_req=1",
                     grant_idx, out_req, g);
        end
        n_cmp++;
        if (out_data !== word[g]) begin
            n_err++;
            $display("FAIL out_data: got %h want %h", out_data, word[g]);
        end
        repeat (ack_delay) begin
            step();
            n_cmp++;
            if (out_req !== 1'b1 || in_ack !== '0) begin
                n_err++;
                $display("FAIL req_hold: got out_req=%b in_ack=%b want 1/0000", out_req, in_ack);
            end
        end
        out_ack = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 16 && !seen; t++) begin
            step();
            if (in_ack != '0) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || in_ack !== (4'b0001 << g) || out_req !== 1'b0) begin
            n_err++;
            $display("FAIL in_ack: got %b out_req=%b want %b out_req=0",
                     in_ack, out_req, 4'b0001 << g);
        end
        in_req[g] = 1'b0;
        out_ack = 1'b0;
        step();
        n_cmp++;
        if (in_ack !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL release: got in_ack=%b busy=%b want 0000/0", in_ack, busy);
        end
        n_cmp++;
        if (timeout_err !== m_err) begin
            n_err++;
            $display("FAIL timeout_flag: got %b want %b", timeout_err, m_err);
        end
        m_ptr = (g + 1) % N;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (in_ack !== '0 || out_req !== 1'b0 || out_data !== '0 || grant_idx !== '0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: in_ack=%b out_req=%b data=%h idx=%0d busy=%b err=%b want all 0",
                     in_ack, out_req, out_data, grant_idx, busy, timeout_err);
        end
        rst = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        int g;
        for (int i = 0; i < N; i++) word[i] = 32'hF000_0000 + i;
        for (int k = 0; k < 8; k++) begin
            run_word(4'b1111, 0, g);
            n_cmp++;
            if (g !== k % N) begin
                n_err++;
                $display("FAIL fairness[%0d]: got grant %0d want %0d", k, g, k % N);
            end
        end
    endtask

    task automatic test_single();
        int g;
        word[1] = 32'hA5A5_0001;
        run_word(4'b0010, 1, g);
        n_cmp++;
        if (g !== 1) begin
            n_err++;
            $display("FAIL single: got grant %0d want 1", g);
        end
    endtask

    task automatic test_rotation();
        int g;
        in_req = 4'b0011;
        step();
        n_cmp++;
        if (grant_idx !== 2'd0 || out_req !== 1'b1) begin
            n_err++;
            $display("FAIL rot_first: got idx=%0d out_req=%b want 0/1", grant_idx, out_req);
        end
        in_req[3] = 1'b1;
        step();
        n_cmp++;
        if (grant_idx !== 2'd0 || out_req !== 1'b1 || out_data !== word[0]) begin
            n_err++;
            $display("FAIL rot_hold: got idx=%0d out_req=%b data=%h want 0/1/%h",
                     grant_idx, out_req, out_data, word[0]);
        end
        out_ack = 1'b1;
        step();
        n_cmp++;
        if (in_ack !== 4'b0001) begin
            n_err++;
            $display("FAIL rot_ack: got %b want 0001", in_ack);
        end
        in_req[0] = 1'b0;
        out_ack = 1'b0;
        step();
        m_ptr = 1;
        run_word(in_req, 0, g);
        n_cmp++;
        if (g !== 1) begin
            n_err++;
            $display("FAIL rot_second: got grant %0d want 1", g);
        end
        run_word(in_req, 0, g);
        n_cmp++;
        if (g !== 3) begin
            n_err++;
            $display("FAIL rot_third: got grant %0d want 3", g);
        end
    endtask

    task automatic test_early_release();
        int g;
        word[2] = 32'hC0DE_0002;
        in_req = 4'b0100;
        step();
        in_req = 4'b0001;
        step();
        n_cmp++;
        if (out_req !== 1'b1 || out_data !== 32'hC0DE_0002 || grant_idx !== 2'd2) begin
            n_err++;
            $display("FAIL early_req: got out_req=%b data=%h idx=%0d want 1/c0de0002/2",
                     out_req, out_data, grant_idx);
        end
        out_ack = 1'b1;
        step();
        n_cmp++;
        if (in_ack !== 4'b0100) begin
            n_err++;
            $display("FAIL early_ack: got %b want 0100", in_ack);
        end
        step();
        n_cmp++;
        if (in_ack !== 4'b0100) begin
            n_err++;
            $display("FAIL early_hold: got %b want 0100", in_ack);
        end
        out_ack = 1'b0;
        step();
        n_cmp++;
        if (in_ack !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL early_exit: got in_ack=%b busy=%b want 0000/0", in_ack, busy);
        end
        m_ptr = 3;
        run_word(4'b0001, 0, g);
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] req;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) word[i] = $urandom;
            req = 4'($urandom_range(1, 15));
            run_word(req, int'($urandom_range(0, 3)), g);
        end
    endtask

    task automatic test_watchdog();
        int g;
        in_req = 4'b0100;
        g = model_pick(4'b0100, m_ptr);
        step();
        for (int c = 1; c <= TO + 3; c++) begin
            step();
            n_cmp++;
            if (timeout_err !== 1'(c >= TO) || out_req !== 1'b1) begin
                n_err++;
                $display("FAIL watchdog[%0d]: got err=%b out_req=%b want err=%b out_req=1",
                         c, timeout_err, out_req, c >= TO);
            end
        end
        out_ack = 1'b1;
        step();
        n_cmp++;
        if (in_ack !== (4'b0001 << g)) begin
            n_err++;
            $display("FAIL wd_ack: got %b want %b", in_ack, 4'b0001 << g);
        end
        in_req = '0;
        out_ack = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL wd_sticky: got busy=%b err=%b want 0/1", busy, timeout_err);
        end
        m_err = 1'b1;
        m_ptr = (g + 1) % N;
    endtask

    task automatic test_reset_mid();
        int g;
        in_req = 4'b1111;
        g = model_pick(4'b1111, m_ptr);
        step();
        n_cmp++;
        if (out_req !== 1'b1 || grant_idx !== 2'(g)) begin
            n_err++;
            $display("FAIL mid_pre: got out_req=%b idx=%0d want 1/%0d", out_req, grant_idx, g);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ack !== '0 || out_req !== 1'b0 || out_data !== '0 || grant_idx !== '0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: in_ack=%b out_req=%b data=%h idx=%0d busy=%b err=%b",
                     in_ack, out_req, out_data, grant_idx, busy, timeout_err);
        end
        step();
        rst = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
        run_word(4'b1111, 0, g);
        n_cmp++;
        if (g !== 0) begin
            n_err++;
            $display("FAIL mid_ptr: got grant %0d want 0", g);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) word[i] = '0;
        test_reset();
        test_fairness();
        test_single();
        test_rotation();
        test_early_release();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
